// File: rtl/cpu_control_unit_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   - instruction opcodes (OP_NOP..OP_HLT), taken from instr[7:4]
//   - ALU function encodings (ALU_PASS..ALU_XOR) driven on alu_op
//   - sequencer state encoding (ST_IDLE..ST_HALTED)
//   - decoded-instruction record produced by cpu_decoder
// Imported by the control unit, its decoder, the ALU and the testbench.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_CLR = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       writes_acc;
        logic       is_jump;
        logic       is_jz;
        logic       is_clr;
        logic       is_out;
        logic       is_hlt;
        logic       is_illegal;
    } dec_t;

    // Opcode field of an 8-bit instruction word.
    function automatic logic [3:0] instr_opcode(input logic [7:0] instr);
        return instr[7:4];
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: bundles the control unit's connections to the program
// ROM, the ALU and the accumulator register.
//   imem_addr  ROM address (control -> ROM)
//   imem_rdata ROM data, one cycle after imem_addr (ROM -> control)
//   acc_q      accumulator value (accumulator -> control)
//   alu_op     ALU function select (control -> ALU)
//   alu_b      ALU B operand, zero-extended immediate (control -> ALU)
//   reg_save   accumulator load strobe (control -> accumulator)
//   reg_clear  accumulator clear strobe (control -> accumulator)
//   out_strobe acc_q is the port output this cycle (control -> output port)
// Modports: master = control unit side, slave = datapath/ROM side.
interface cpu_control_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_rdata;
    logic [DATA_W-1:0] acc_q;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_b;
    logic              reg_save;
    logic              reg_clear;
    logic              out_strobe;

    modport master (
        output imem_addr, alu_op, alu_b, reg_save, reg_clear, out_strobe,
        input  imem_rdata, acc_q
    );

    modport slave (
        input  imem_addr, alu_op, alu_b, reg_save, reg_clear, out_strobe,
        output imem_rdata, acc_q
    );
endinterface

// File: rtl/cpu_control_unit_decoder.sv
// cpu_decoder: purely combinational opcode decoder.
//   opcode in  4   instruction bits [7:4]
//   dec    out     decoded record: ALU function, accumulator write, jump/JZ,
//                  CLR, OUT, HLT and illegal-opcode flags
// Opcodes B..E are undefined: they behave as NOP and raise is_illegal.
import cpu_pkg::*;

module cpu_decoder (
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        dec.alu_op = ALU_PASS;
        case (opcode)
            OP_NOP: ;
            OP_LDI: begin dec.alu_op = ALU_PASS; dec.writes_acc = 1'b1; end
            OP_ADD: begin dec.alu_op = ALU_ADD;  dec.writes_acc = 1'b1; end
            OP_SUB: begin dec.alu_op = ALU_SUB;  dec.writes_acc = 1'b1; end
            OP_AND: begin dec.alu_op = ALU_AND;  dec.writes_acc = 1'b1; end
            OP_OR:  begin dec.alu_op = ALU_OR;   dec.writes_acc = 1'b1; end
            OP_XOR: begin dec.alu_op = ALU_XOR;  dec.writes_acc = 1'b1; end
            OP_JMP: dec.is_jump = 1'b1;
            OP_JZ:  dec.is_jz   = 1'b1;
            OP_CLR: dec.is_clr  = 1'b1;
            OP_OUT: dec.is_out  = 1'b1;
            OP_HLT: dec.is_hlt  = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 8-bit CPU datapath.
// Each instruction runs FETCH -> DECODE -> EXECUTE, plus WRITEBACK for
// LDI/ALU instructions; HLT parks the sequencer in HALTED.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   begin at PC=0; honoured only in IDLE or HALTED
//   bus      master side of cpu_control_unit_if (ROM, ALU, accumulator)
//   busy     out  high in FETCH/DECODE/EXECUTE/WRITEBACK
//   halted   out  high in HALTED
//   illegal  out  sticky undefined-opcode flag, cleared by start or reset
// Every output is a flop loaded from the next-state decision, so a strobe
// lands exactly in the state it belongs to and reset kills it at once.
import cpu_pkg::*;

module cpu_control_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    cpu_control_unit_if.master          bus,
    output logic                        busy,
    output logic                        halted,
    output logic                        illegal
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        ir;
    logic [7:0]        dec_instr;
    dec_t              dec;
    logic              acc_zero;
    logic              launch;

    logic [ADDR_W-1:0] imem_addr_q;
    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              reg_save_q;
    logic              reg_clear_q;
    logic              out_strobe_q;
    logic              busy_q;
    logic              halted_q;
    logic              illegal_q;

    // In DECODE the word is still on the ROM bus; decoding it there lets the
    // EXECUTE-cycle outputs be registered on the DECODE->EXECUTE edge.
    assign dec_instr = (state == ST_DECODE) ? bus.imem_rdata : ir;

    cpu_decoder u_decoder (
        .opcode (instr_opcode(dec_instr)),
        .dec    (dec)
    );

    assign acc_zero = (bus.acc_q == '0);
    assign launch   = ((state == ST_IDLE) || (state == ST_HALTED)) && start;

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == ST_DECODE) begin
                ir <= bus.imem_rdata;
            end
        end
    end

    // ---- next-state / PC logic ----
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                end
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (dec.is_hlt) begin
                    state_nxt = ST_HALTED;
                end else if (dec.writes_acc) begin
                    state_nxt = ST_WRITEBACK;
                end else begin
                    state_nxt = ST_FETCH;
                end
                // PC wraps silently at 2**ADDR_W; HLT keeps it pointing at itself.
                if (dec.is_jump || (dec.is_jz && acc_zero)) begin
                    pc_nxt = ADDR_W'(ir[3:0]);
                end else if (!dec.is_hlt) begin
                    pc_nxt = pc + ADDR_W'(1);
                end
            end
            ST_WRITEBACK: state_nxt = ST_FETCH;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // ---- registered outputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_addr_q  <= '0;
            alu_op_q     <= ALU_PASS;
            alu_b_q      <= '0;
            reg_save_q   <= 1'b0;
            reg_clear_q  <= 1'b0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (state_nxt == ST_FETCH) begin
                imem_addr_q <= pc_nxt;
            end

            // Operand is set up entering EXECUTE and held through WRITEBACK.
            if (state == ST_DECODE) begin
                alu_op_q <= dec.alu_op;
                alu_b_q  <= DATA_W'(bus.imem_rdata[3:0]);
            end else if ((state_nxt == ST_HALTED) || (state_nxt == ST_IDLE)) begin
                alu_op_q <= ALU_PASS;
                alu_b_q  <= '0;
            end

            reg_save_q   <= (state_nxt == ST_WRITEBACK);
            reg_clear_q  <= (state == ST_DECODE) && dec.is_clr;
            out_strobe_q <= (state == ST_DECODE) && dec.is_out;

            busy_q   <= (state_nxt inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK});
            halted_q <= (state_nxt == ST_HALTED);

            if (launch) begin
                illegal_q <= 1'b0;
            end else if ((state == ST_EXECUTE) && dec.is_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.imem_addr  = imem_addr_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.reg_save   = reg_save_q;
    assign bus.reg_clear  = reg_clear_q;
    assign bus.out_strobe = out_strobe_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: program ROM and accumulator/ALU models
// around the DUT, plus an instruction-level reference that turns a ROM image
// into the expected per-cycle observation trace.
import cpu_pkg::*;

module tb_cpu_control_unit;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int ROM_N  = 1 << ADDR_W;

    logic clk;
    logic reset_n;
    logic start;
    logic busy;
    logic halted;
    logic illegal;

    cpu_control_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cpu_control_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus.master),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program ROM.
    logic [7:0] rom [ROM_N];
    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    // Accumulator + ALU as the rest of the datapath would implement them.
    logic [DATA_W-1:0] acc_reg;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_reg <= '0;
        else if (bus.reg_clear) acc_reg <= '0;
        else if (bus.reg_save) begin
            case (bus.alu_op)
                ALU_PASS: acc_reg <= bus.alu_b;
                ALU_ADD:  acc_reg <= acc_reg + bus.alu_b;
                ALU_SUB:  acc_reg <= acc_reg - bus.alu_b;
                ALU_AND:  acc_reg <= acc_reg & bus.alu_b;
                ALU_OR:   acc_reg <= acc_reg | bus.alu_b;
                ALU_XOR:  acc_reg <= acc_reg ^ bus.alu_b;
                default:  acc_reg <= acc_reg;
            endcase
        end
    end
    assign bus.acc_q = acc_reg;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One expected observation per clock cycle after the start edge.
    typedef struct {
        bit busy, halted, save, clr, outs, ill;
        bit chk_addr;  int addr;
        bit chk_alu;   int aop; int ab;
        bit chk_acc;   int acc;
    } exp_t;

    exp_t tr[$];
    int   m_acc = 0;   // architectural accumulator as the program sees it
    bit   m_ill = 0;

    function automatic int alu_code(input int op);
        case (op)
            1: return 0;  2: return 1;  3: return 2;
            4: return 3;  5: return 4;  6: return 5;
            default: return 0;
        endcase
    endfunction

    // Instruction-level execution of the ROM image, starting at PC 0.
    task automatic build_trace(input int limit, output bit done_halt);
        int pc, op, imm;
        bit writes, taken;
        exp_t e;
        pc = 0;
        tr.delete();
        m_ill = 0;
        done_halt = 0;
        while (tr.size() < limit) begin
            op  = int'(rom[pc][7:4]);
            imm = int'(rom[pc][3:0]);
            writes = (op >= 1 && op <= 6);
            taken  = (op == 7) || (op == 8 && m_acc == 0);

            e = '{default: 0};
            e.busy = 1; e.ill = m_ill;
            e.chk_addr = 1; e.addr = pc;
            tr.push_back(e);                       // fetch
            e.chk_addr = 0;
            tr.push_back(e);                       // decode
            if (writes) begin e.chk_alu = 1; e.aop = alu_code(op); e.ab = imm; end
            e.clr  = (op == 9);
            e.outs = (op == 10);
            if (op == 10) begin e.chk_acc = 1; e.acc = m_acc; end
            tr.push_back(e);                       // execute
            e.clr = 0; e.outs = 0; e.chk_acc = 0;

            if (op >= 11 && op <= 14) m_ill = 1;
            case (op)
                1: m_acc = imm;
                2: m_acc = (m_acc + imm) & 255;
                3: m_acc = (m_acc - imm) & 255;
                4: m_acc = m_acc & imm;
                5: m_acc = m_acc | imm;
                6: m_acc = m_acc ^ imm;
                9: m_acc = 0;
                default: ;
            endcase

            if (writes) begin
                e.save = 1; e.ill = m_ill;
                tr.push_back(e);                   // writeback
            end

            if (op == 15) begin
                e = '{default: 0};
                e.halted = 1; e.ill = m_ill;
                e.chk_addr = 1; e.addr = pc;
                e.chk_alu = 1; e.aop = 0; e.ab = 0;
                e.chk_acc = 1; e.acc = m_acc;
                tr.push_back(e);
                done_halt = 1;
                break;
            end else if (taken) begin
                pc = imm;
            end else begin
                pc = (pc + 1) % ROM_N;
            end
        end
    endtask

    // Asynchronous reset in the low clock phase, outputs must clear at once.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_save",    int'(bus.reg_save),   0);
        check_eq("rst_clear",   int'(bus.reg_clear),  0);
        check_eq("rst_out",     int'(bus.out_strobe), 0);
        check_eq("rst_busy",    int'(busy),           0);
        check_eq("rst_halted",  int'(halted),         0);
        check_eq("rst_illegal", int'(illegal),        0);
        check_eq("rst_addr",    int'(bus.imem_addr),  0);
        check_eq("rst_aluop",   int'(bus.alu_op),     0);
        check_eq("rst_alub",    int'(bus.alu_b),      0);
        @(negedge clk);
        reset_n = 1'b1;
        m_acc = 0;
    endtask

    task automatic run_prog(input int limit, input bit rand_start);
        bit h;
        build_trace(limit, h);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < tr.size(); k++) begin
            @(negedge clk);
            check_eq("busy",    int'(busy),           int'(tr[k].busy));
            check_eq("halted",  int'(halted),         int'(tr[k].halted));
            check_eq("save",    int'(bus.reg_save),   int'(tr[k].save));
            check_eq("clear",   int'(bus.reg_clear),  int'(tr[k].clr));
            check_eq("out",     int'(bus.out_strobe), int'(tr[k].outs));
            check_eq("illegal", int'(illegal),        int'(tr[k].ill));
            if (tr[k].chk_addr) check_eq("imem_addr", int'(bus.imem_addr), tr[k].addr);
            if (tr[k].chk_alu) begin
                check_eq("alu_op", int'(bus.alu_op), tr[k].aop);
                check_eq("alu_b",  int'(bus.alu_b),  tr[k].ab);
            end
            if (tr[k].chk_acc) check_eq("acc", int'(bus.acc_q), tr[k].acc);
            // Stray start pulses while busy must change nothing.
            start = tr[k].busy && rand_start && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        if (!h) do_reset();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < ROM_N; i++) rom[i] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        clear_rom();
        repeat (2) @(negedge clk);
        check_eq("idle_busy",    int'(busy),          0);
        check_eq("idle_halted",  int'(halted),        0);
        check_eq("idle_illegal", int'(illegal),       0);
        check_eq("idle_addr",    int'(bus.imem_addr), 0);
        check_eq("idle_save",    int'(bus.reg_save),  0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset dropped while the LDI writeback strobe is up.
        rom[0] = 8'h15; rom[1] = 8'hF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !bus.reg_save; i++) @(negedge clk);
        check_eq("wb_reached", int'(bus.reg_save), 1);
        do_reset();
        check_eq("post_rst_acc", int'(bus.acc_q), 0);

        // LDI 5; ADD 3; OUT; HLT
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'hA0; rom[3] = 8'hF0;
        run_prog(200, 1'b0);
        check_eq("prog_acc", int'(bus.acc_q), 8);

        // CLR; JZ 4 taken
        clear_rom();
        rom[0] = 8'h90; rom[1] = 8'h84; rom[4] = 8'hF0;
        run_prog(200, 1'b0);
        check_eq("jz_taken_pc", int'(bus.imem_addr), 4);

        // LDI 7; JZ 4 not taken
        clear_rom();
        rom[0] = 8'h17; rom[1] = 8'h84; rom[2] = 8'hF0; rom[4] = 8'hF0;
        run_prog(200, 1'b0);
        check_eq("jz_fall_pc", int'(bus.imem_addr), 2);

        // JMP 15; NOP at 15 wraps to 0 (endless loop, ended by reset)
        clear_rom();
        rom[0] = 8'h7F; rom[15] = 8'h00;
        run_prog(16, 1'b1);

        // Illegal opcode, then restart from HALTED clears the flag
        clear_rom();
        rom[0] = 8'hB0; rom[1] = 8'hF0;
        run_prog(200, 1'b0);
        check_eq("ill_sticky", int'(illegal), 1);
        rom[0] = 8'hF0;
        run_prog(200, 1'b0);

        // Random programs with stray start pulses
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) rom[ROM_N-1] = 8'hF0;
            run_prog(120, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
